// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for an external combinational ALU.
// Each instruction walks IDLE -> READ -> EXEC -> WB. Operands come from a
// small register file, the ALU result is captured, and the result is written
// back unless the instruction overflowed, targets r0, or uses an illegal opcode.
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic             ld_en,
  input  logic [3:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] result_out,
  output logic             done,
  output logic             ovf_flag,
  output logic             illegal_flag,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Instruction register, filled on accept.
  logic [3:0] op_p0;
  logic [3:0] rd_p0;
  logic [3:0] rs_p0;
  logic [3:0] rt_p0;

  // Overflow captured in EXEC, only meaningful for add/sub.
  logic ovf_cap;

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  logic accept;
  logic load_we;
  logic read_en;
  logic exec_en;
  logic wb_en;
  logic wb_we;
  logic wb_ovf;
  logic wb_ill;

  // Opcodes 11..15 are treated as illegal.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op >= 4'd11);
  endfunction

  // Only add (2) and sub (3) report a meaningful overflow.
  function automatic logic op_ovf_checked(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    load_we     = 1'b0;
    read_en     = 1'b0;
    exec_en     = 1'b0;
    wb_en       = 1'b0;
    wb_we       = 1'b0;
    wb_ovf      = 1'b0;
    wb_ill      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
        // Loads only land while idle; r0 is hard-wired to zero.
        load_we     = ld_en && (ld_addr != 4'd0);
        if (instr_valid) state_nxt = S_READ;
      end
      S_READ: begin
        read_en   = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        exec_en   = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        done      = 1'b1;
        wb_en     = 1'b1;
        wb_ovf    = ovf_cap;
        wb_ill    = op_illegal(op_p0);
        wb_we     = (rd_p0 != 4'd0) && !ovf_cap && !op_illegal(op_p0);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accept boundary: latch instruction fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0 <= 4'd0;
      rd_p0 <= 4'd0;
      rs_p0 <= 4'd0;
      rt_p0 <= 4'd0;
    end else if (accept) begin
      op_p0 <= instr[15:12];
      rd_p0 <= instr[11:8];
      rs_p0 <= instr[7:4];
      rt_p0 <= instr[3:0];
    end
  end

  // READ boundary: present operands and opcode to the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 4'd0;
    end else if (read_en) begin
      alu_a  <= rs_val;
      alu_b  <= rt_val;
      alu_op <= op_p0;
    end
  end

  // EXEC boundary: capture the ALU result and the relevant overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_out <= '0;
      ovf_cap    <= 1'b0;
    end else if (exec_en) begin
      result_out <= alu_result;
      ovf_cap    <= alu_overflow & op_ovf_checked(op_p0);
    end
  end

  // WB boundary: sticky status flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag     <= 1'b0;
      illegal_flag <= 1'b0;
    end else if (wb_en) begin
      if (wb_ovf) ovf_flag     <= 1'b1;
      if (wb_ill) illegal_flag <= 1'b1;
    end
  end

  // Register file: direct loads while idle, write-back in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (load_we) begin
      rf[ld_addr] <= ld_data;
    end else if (wb_we) begin
      rf[rd_p0] <= result_out;
    end
  end

  // Read ports; r0 always reads as zero.
  always_comb begin
    rs_val   = (rs_p0 == 4'd0)    ? '0 : rf[rs_p0];
    rt_val   = (rt_p0 == 4'd0)    ? '0 : rf[rt_p0];
    dbg_data = (dbg_addr == 4'd0) ? '0 : rf[dbg_addr];
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a reference ALU drives the DUT's ALU inputs, a
// transaction-level model predicts every output, and directed scenarios add
// literal expectations.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [31:0] result_out;
  logic        done, ovf_flag, illegal_flag;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] dbg_rot = 4'd0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .result_out(result_out), .done(done), .ovf_flag(ovf_flag),
    .illegal_flag(illegal_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: {overflow, result}. The overflow line carries junk
  // (result bit 0) for opcodes other than add/sub, so it must be masked.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    logic v;
    sa = a; sb = b;
    case (op)
      4'd0: r = a;
      4'd1: r = ~a;
      4'd2: r = sa + sb;
      4'd3: r = sa - sb;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      default: r = 32'hFFFF_FFFF;
    endcase
    if (op == 4'd2)      v = (sa[31] == sb[31]) && (r[31] != sa[31]);
    else if (op == 4'd3) v = (sa[31] != sb[31]) && (r[31] != sa[31]);
    else                 v = r[0];
    return {v, r};
  endfunction

  assign {alu_overflow, alu_result} = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted instruction is evaluated immediately on
  // the model register file; its visible effects are released 1, 2 and 3
  // edges later (operands, result, write-back).
  logic [31:0] mrf [16];
  logic        mvalid = 1'b0;
  int          since  = -1;
  logic [31:0] ma, mb, mres, pa, pb, p_res;
  logic [3:0]  mop, p_op, p_rd;
  logic        movf, mill, p_ovf;
  logic [32:0] p_alu;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mvalid = 1'b1;
      for (int i = 0; i < 16; i++) mrf[i] = 32'h0;
      ma = 0; mb = 0; mop = 0; mres = 0; movf = 0; mill = 0;
      since = -1;
    end else if (since < 0) begin
      if (ld_en && ld_addr != 4'd0) mrf[ld_addr] = ld_data;
      if (instr_valid) begin
        p_op  = instr[15:12];
        p_rd  = instr[11:8];
        pa    = mrf[instr[7:4]];
        pb    = mrf[instr[3:0]];
        p_alu = alu_f(pa, pb, p_op);
        p_res = p_alu[31:0];
        p_ovf = p_alu[32] && (p_op == 4'd2 || p_op == 4'd3);
        since = 0;
      end
    end else begin
      since++;
      if (since == 1) begin ma = pa; mb = pb; mop = p_op; end
      if (since == 2) mres = p_res;
      if (since == 3) begin
        if (p_rd != 0 && !p_ovf && p_op < 4'd11) mrf[p_rd] = p_res;
        if (p_ovf) movf = 1'b1;
        if (p_op >= 4'd11) mill = 1'b1;
        since = -1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, since < 0});
      chk("done", {31'd0, done}, {31'd0, since == 2});
      chk("alu_a", alu_a, ma);
      chk("alu_b", alu_b, mb);
      chk("alu_op", {28'd0, alu_op}, {28'd0, mop});
      chk("result_out", result_out, mres);
      chk("ovf_flag", {31'd0, ovf_flag}, {31'd0, movf});
      chk("illegal_flag", {31'd0, illegal_flag}, {31'd0, mill});
      chk("dbg_data", dbg_data, (dbg_addr == 4'd0) ? 32'h0 : mrf[dbg_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    dbg_addr = dbg_rot;
    dbg_rot++;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Offer one instruction, check accept-to-done latency, finish write-back.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input string nm);
    int n;
    bit seen;
    instr = {op, rd, rs, rt};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin tick(); n++; end
    chk({nm, " ready"}, {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    ld_en = 1'b0;
    seen = 1'b0;
    n = 1;
    while (!seen && n < 8) begin
      if (done) seen = 1'b1;
      else begin tick(); n++; end
    end
    chk({nm, " latency"}, n, 32'd3);
    tick();
  endtask

  logic [31:0] v;
  int a1, a2, n;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; ld_en = 1'b0;
    ld_addr = 4'd0; ld_data = 32'h0; dbg_addr = 4'd0;
    tick(); tick();
    rst = 1'b0;
    chk("ready after reset", {31'd0, instr_ready}, 32'd1);
    chk("done after reset", {31'd0, done}, 32'd0);

    // ADD r3 = r1 + r2
    load(4'd1, 32'h0000_0005);
    load(4'd2, 32'h0000_0003);
    issue(4'd2, 4'd3, 4'd1, 4'd2, "add");
    peek(4'd3, v); chk("r3 sum", v, 32'h0000_0008);
    chk("ovf clear", {31'd0, ovf_flag}, 32'd0);

    // Signed overflow suppresses the write
    load(4'd1, 32'h7FFF_FFFF);
    load(4'd2, 32'h0000_0001);
    issue(4'd2, 4'd4, 4'd1, 4'd2, "add ovf");
    chk("ovf set", {31'd0, ovf_flag}, 32'd1);
    peek(4'd4, v); chk("r4 untouched", v, 32'h0);

    // Illegal opcode, then a write aimed at r0
    issue(4'hC, 4'd5, 4'd1, 4'd2, "illegal");
    chk("illegal set", {31'd0, illegal_flag}, 32'd1);
    peek(4'd5, v); chk("r5 untouched", v, 32'h0);
    issue(4'd3, 4'd0, 4'd1, 4'd2, "sub r0");
    peek(4'd0, v); chk("r0 zero", v, 32'h0);
    load(4'd0, 32'hFFFF_FFFF);
    peek(4'd0, v); chk("r0 load dropped", v, 32'h0);

    // Back-to-back with instr_valid held; a load during EXEC is ignored
    instr = {4'd4, 4'd9, 4'd1, 4'd2};
    instr_valid = 1'b1;
    a1 = -1; a2 = -1; n = 0;
    while (a2 < 0 && n < 20) begin
      if (instr_ready) begin
        if (a1 < 0) a1 = cyc;
        else        a2 = cyc;
      end
      tick(); n++;
      if (a1 >= 0 && a2 < 0) begin
        instr   = {4'd5, 4'd10, 4'd1, 4'd2};
        ld_en   = (cyc - a1 == 2);
        ld_addr = 4'd11;
        ld_data = 32'hDEAD_BEEF;
      end
    end
    instr_valid = 1'b0;
    ld_en = 1'b0;
    chk("issue spacing", a2 - a1, 32'd4);
    tick(); tick(); tick();
    peek(4'd9, v);  chk("r9 and", v, 32'h0000_0001);
    peek(4'd10, v); chk("r10 or", v, 32'h7FFF_FFFF);
    peek(4'd11, v); chk("r11 busy load", v, 32'h0);
    chk("and ovf masked", {31'd0, ovf_flag}, 32'd1);

    // Reset in EXEC aborts ADD r6
    load(4'd1, 32'h0000_0005);
    load(4'd2, 32'h0000_0003);
    instr = {4'd2, 4'd6, 4'd1, 4'd2};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ready after abort", {31'd0, instr_ready}, 32'd1);
    tick(); tick(); tick();
    peek(4'd6, v); chk("r6 aborted", v, 32'h0);
    chk("ovf cleared", {31'd0, ovf_flag}, 32'd0);
    chk("illegal cleared", {31'd0, illegal_flag}, 32'd0);

    // Load and accept on the same edge: NOT sees the new r7
    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'hA5A5_A5A5;
    issue(4'd1, 4'd8, 4'd7, 4'd0, "not");
    peek(4'd8, v); chk("r8 not", v, 32'h5A5A_5A5A);
    issue(4'd0, 4'd12, 4'd7, 4'd0, "move");
    peek(4'd12, v); chk("r12 move", v, 32'hA5A5_A5A5);
    issue(4'd3, 4'd13, 4'd7, 4'd12, "sub zero");
    peek(4'd13, v); chk("r13 sub", v, 32'h0);
    chk("ovf still clear", {31'd0, ovf_flag}, 32'd0);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; NREGS, 16, register-file entries (4-bit index).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
REQ-006 instr_ready  output  1  high only in IDLE; accept = instr_valid & instr_ready.
REQ-007 ld_en / ld_addr / ld_data  input  1/4/WIDTH  direct register-file load.
REQ-008 alu_a  output  WIDTH  registered operand A, drives ALU R2.
REQ-009 alu_b  output  WIDTH  registered operand B, drives ALU R3.
REQ-010 alu_op  output  4  registered opcode, drives ALU Opcode.
REQ-011 alu_result  input  WIDTH  ALU R1 (combinational from alu_a/alu_b/alu_op).
REQ-012 alu_overflow  input  1  ALU overflow (valid for opcodes 2, 3 only).
REQ-013 result_out  output  WIDTH  last captured ALU result.
REQ-014 done  output  1  one-cycle pulse in WB state.
REQ-015 ovf_flag / illegal_flag  output  1/1  sticky status, cleared only by rst.
REQ-016 dbg_addr  input  4; dbg_data  output  WIDTH  combinational register-file read.

Function
REQ-017 FSM states IDLE, READ, EXEC, WB; IDLE->READ on accept; READ->EXEC->WB->IDLE unconditionally.
REQ-018 On accept, rd/rs/rt/opcode latched into internal instruction register.
REQ-019 READ: alu_a <= reg[rs], alu_b <= reg[rt], alu_op <= opcode.
REQ-020 EXEC: result_out <= alu_result; internal ovf_cap <= alu_overflow & (opcode==2 | opcode==3).
REQ-021 WB: done=1; reg[rd] <= result_out unless rd==0, ovf_cap==1, or opcode in 11..15.
REQ-022 Register 0 reads as zero always; writes to it (WB or load) discarded.
REQ-023 ovf_cap==1 in WB: write suppressed, ovf_flag set.
REQ-024 Opcode 11..15 in WB: write suppressed, illegal_flag set, done still pulses.
REQ-025 Latency accept-edge to WB write-edge = 3 cycles; max throughput one instruction per 4 cycles.
REQ-026 instr_valid while not IDLE ignored; instr contents not sampled.
REQ-027 ld_en honoured only in IDLE (ignored in READ/EXEC/WB); addr 0 discarded.
REQ-028 ld_en and accept on same edge: load applied that edge; READ sees loaded value.
REQ-029 dbg_data shows pre-write value until WB edge, new value afterwards.
REQ-030 Opcode passed unmodified; opcodes 0 (move) and 1 (not) still drive alu_b from rt.

Reset
REQ-031 rst high at edge: state IDLE, all registers 0, alu_a/alu_b/alu_op/result_out 0, done 0, ovf_flag 0, illegal_flag 0.
REQ-032 rst has priority over accept, load and WB; rst in READ/EXEC/WB aborts, no write occurs.
REQ-033 instr_ready high in first cycle after rst deasserts.

Verification
REQ-034 Load r1=0x00000005, r2=0x00000003; issue ADD rd=3 rs=1 rt=2 -> done 3 cycles after accept, dbg r3=0x00000008, ovf_flag 0.
REQ-035 r1=0x7FFFFFFF, r2=0x00000001; ADD rd=4 -> ovf_flag 1, r4 stays 0, done pulses.
REQ-036 Opcode 0xC rd=5 -> illegal_flag 1, r5 unchanged; SUB rd=0 -> r0 reads 0.
REQ-037 instr_valid held high with two instructions -> second accepted exactly 4 cycles after first; ld_en in EXEC ignored.
REQ-038 rst asserted in EXEC of ADD rd=6 -> r6=0, state IDLE, instr_ready 1 next cycle.
REQ-039 ld_en r7=0xA5A5A5A5 with accept of NOT rd=8 rs=7 same edge -> r8=0x5A5A5A5A.
